usignal_capture: RTL and testbench
==================================

// Module: usignal_capture
// PURPOSE
// - Synthesizable capture of a 16-bit unsigned signal (phase current, encoder angle, PWM duty) in the PMSM core.
// - Decimates the input by a programmable period and stores LEN samples in on-chip RAM after a trigger.
// - Streams the record out as a header word (period) followed by the samples, in the same layout the bench
//   stimulus files use, so a captured run can be replayed by the stimulus model.
// PARAMETERS
// - DW     16    sample width, bits
// - DEPTH  1024  buffer depth, samples; power of two
// - AW     $clog2(DEPTH)  address width; derived, do not override
// - DIVW   16    width of sample-period register
// PORTS
// - clk       in   1      system clock
// - rst_n     in   1      synchronous reset, active low
// - sig_in    in   DW     signal under capture, sampled on clk
// - div       in   DIVW   sample period minus 1, in clk cycles; latched on arm
// - len       in   AW+1   samples to record, 1..DEPTH; 0 or >DEPTH means DEPTH; latched on arm
// - arm       in   1      1-cycle pulse: start a capture; ignored unless IDLE
// - trig      in   1      level trigger; capture starts on the first strobe with trig=1 while ARMED
// - abort     in   1      return to IDLE from any state next cycle; highest priority after reset
// - m_data    out  DW     readout word
// - m_valid   out  1      readout word valid
// - m_ready   in   1      downstream accepts when m_valid && m_ready
// - m_last    out  1      marks final sample of the record
// - busy      out  1      high in ARMED, CAPTURE, READOUT
// - overrun   out  1      sticky: arm seen while busy; cleared by next accepted arm
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): state IDLE; m_data=0, m_valid=0, m_last=0, busy=0, overrun=0; dividers and pointers 0.
// - Strobe: free-running divider counts 0..div_q, strobe when count==div_q; div_q=0 -> strobe every cycle.
//   Divider restarts at 0 on arm acceptance.
// - FSM states and transitions:
//   - IDLE -> ARMED on arm. Latches div_q, len_q.
//   - ARMED -> CAPTURE on strobe && trig. That strobe's sig_in is sample 0 and is written to addr 0.
//   - CAPTURE: write sig_in at each strobe, wptr++. After writing sample len_q-1 -> READOUT. No wrap.
//   - READOUT: word 0 = header {div_q} (zero-extended or truncated to DW), then samples 0..len_q-1.
//     m_last=1 with the last sample only. Last handshake -> IDLE.
//   - abort in any state -> IDLE. Clears m_valid/m_last the next cycle; RAM contents are left untouched.
// - Handshake: AXI-stream rules. m_data/m_last stay stable while m_valid && !m_ready.
//   - m_valid does not depend combinationally on m_ready.
//   - Sustains 1 word/cycle with m_ready held high after the first word.
//   - RAM read latency is 1 cycle; a 2-entry skid/prefetch hides it.
// - Readout is held by backpressure indefinitely; no data loss, no timeout.
// - sig_in is not sampled during READOUT; a new arm is rejected and sets overrun.
// - arm and abort in the same cycle: abort wins and arm is dropped.
// - trig already high when ARMED is entered: capture starts on the first strobe.
// - len=1: header, then one sample with m_last=1.
// - Reset mid-readout: m_valid drops on the reset edge; no partial m_last.
// STRUCTURE
// - Package pmsm_sig_pkg: typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} cap_state_e;
//   localparam SIG_DW=16; typedef logic [SIG_DW-1:0] usig_t.
// - Sub-module usignal_capture_ram: simple dual-port, one write port and one registered read port
//   (1-cycle latency), DEPTH x DW, infers block RAM.
// - Top holds the divider, FSM, write/read pointers and output skid.
// TESTING
// - div=0, len=4, trig=1, sig_in=ramp 100,101,...
//   -> stream 0x0000,100,101,102,103; m_last on 103.
// - div=9, len=3, trig rises at cycle 40 after arm, sig_in=cycle count
//   -> samples spaced 10 clk apart, first at the first strobe >=40; header=9.
// - Same as scenario 1 with m_ready toggling 1010 and random stalls
//   -> identical word sequence; m_data stable through every stall.
// - arm pulsed during CAPTURE -> overrun=1, capture unaffected.
//   A later arm in IDLE -> accepted, overrun=0.
// - abort asserted mid-CAPTURE at sample 2 of len=8 -> busy=0 next cycle, m_valid never rises; new arm works.
// - len=0 with DEPTH=16 and div=0 -> 16 samples plus header; m_last on the 16th sample.

Source files
------------

// File: rtl/pmsm_sig_pkg.sv
// Shared types for the PMSM signal capture path: sample word type and the
// capture controller state encoding.
package pmsm_sig_pkg;

  localparam int SIG_DW = 16;

  typedef logic [SIG_DW-1:0] usig_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    READOUT
  } cap_state_e;

endpackage

// File: rtl/usignal_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port
// with a single cycle of read latency.
module usignal_capture_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; every location is
  // written by a capture before the readout can address it.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/usignal_capture.sv
// Decimating capture of an unsigned signal into on-chip RAM, streamed out as a
// header word (sample period) followed by the recorded samples.
module usignal_capture
  import pmsm_sig_pkg::*;
#(
  parameter int DW    = SIG_DW,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int DIVW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   sig_in,
  input  logic [DIVW-1:0] div,
  input  logic [AW:0]     len,
  input  logic            arm,
  input  logic            trig,
  input  logic            abort,
  output logic [DW-1:0]   m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic            busy,
  output logic            overrun
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  cap_state_e      r_state, w_state_nxt;
  logic [DIVW-1:0] r_div_q, r_div_cnt;
  logic [AW:0]     r_len_q, r_wptr, r_rptr;
  logic            r_overrun;
  logic            r_inflight, r_infl_hdr, r_infl_last;
  logic [DW-1:0]   r_m_data, r_sk_data;
  logic            r_m_valid, r_m_last, r_sk_valid, r_sk_last;

  logic            w_arm_ok, w_strobe, w_we, w_cap_done;
  logic            w_pop, w_issue, w_last_word, w_done;
  logic [1:0]      w_occ;
  logic [AW-1:0]   w_raddr;
  logic [DW-1:0]   w_rdata, w_in_data;

  assign w_arm_ok    = arm && !abort && (r_state == IDLE);
  assign w_strobe    = (r_div_cnt == r_div_q);
  assign w_we        = !abort && w_strobe &&
                       (((r_state == ARMED) && trig) || (r_state == CAPTURE));
  assign w_cap_done  = w_we && (r_wptr == r_len_q - PTR_ONE);

  // Readout word r_rptr: 0 is the header, n>0 is the sample at address n-1.
  // Reads are issued only when the two output slots can absorb them.
  assign w_pop       = r_m_valid && m_ready;
  assign w_occ       = 2'(r_m_valid) + 2'(r_sk_valid) + 2'(r_inflight);
  assign w_issue     = !abort && (r_state == READOUT) && (r_rptr <= r_len_q) &&
                       ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));
  assign w_last_word = (r_rptr == r_len_q);
  assign w_raddr     = r_rptr[AW-1:0] - AW'(1);
  assign w_in_data   = r_infl_hdr ? DW'(r_div_q) : w_rdata;
  assign w_done      = w_pop && r_m_last;

  // NOTE: next-state is defaulted to the current state first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_arm_ok)   w_state_nxt = ARMED;
      ARMED:   if (w_we)       w_state_nxt = w_cap_done ? READOUT : CAPTURE;
      CAPTURE: if (w_cap_done) w_state_nxt = READOUT;
      READOUT: if (w_done)     w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  // NOTE: all registered state uses non-blocking assignments so every
  // always_ff sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_div_q   <= '0;
      r_len_q   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_div_cnt <= (w_arm_ok || w_strobe) ? '0 : r_div_cnt + DIVW'(1);
      if (w_arm_ok) begin
        r_div_q   <= div;
        r_len_q   <= ((len == '0) || (len > LEN_MAX)) ? LEN_MAX : len;
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (arm && !abort && (r_state != IDLE)) r_overrun <= 1'b1;
        if (w_we)    r_wptr <= r_wptr + PTR_ONE;
        if (w_issue) r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      r_inflight  <= 1'b0;
      r_infl_hdr  <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_inflight  <= w_issue;
      r_infl_hdr  <= (r_rptr == '0);
      r_infl_last <= w_last_word;
    end
  end

  // Output register plus one skid slot; the word arriving from RAM goes to
  // whichever slot is next in line so ordering is preserved under stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_sk_data  <= '0;
      r_sk_valid <= 1'b0;
      r_sk_last  <= 1'b0;
    end else if (abort) begin
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_sk_valid <= 1'b0;
    end else if (w_pop || !r_m_valid) begin
      if (r_sk_valid) begin
        r_m_data   <= r_sk_data;
        r_m_last   <= r_sk_last;
        r_m_valid  <= 1'b1;
        r_sk_valid <= r_inflight;
        if (r_inflight) begin
          r_sk_data <= w_in_data;
          r_sk_last <= r_infl_last;
        end
      end else begin
        r_m_valid <= r_inflight;
        r_m_last  <= r_inflight && r_infl_last;
        if (r_inflight) r_m_data <= w_in_data;
      end
    end else if (r_inflight) begin
      r_sk_data  <= w_in_data;
      r_sk_last  <= r_infl_last;
      r_sk_valid <= 1'b1;
    end
  end

  usignal_capture_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (sig_in),
    .i_re    (w_issue),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign busy    = (r_state != IDLE);
  assign overrun = r_overrun;

endmodule

// File: tb/tb_usignal_capture.sv
// Directed bench for usignal_capture with a 16-deep buffer: table-driven
// capture/readout vectors plus hand-written trigger, overrun, abort and reset sequences.
module tb_usignal_capture;
  import pmsm_sig_pkg::*;

  localparam int DEPTH   = 16;
  localparam int MAX_CYC = 600;

  logic        clk = 1'b0;
  logic        rst_n;
  usig_t       sig_in;
  logic [15:0] div;
  logic [4:0]  len;
  logic        arm, trig, abort;
  usig_t       m_data;
  logic        m_valid, m_ready, m_last;
  logic        busy, overrun;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  usignal_capture #(.DW(16), .DEPTH(DEPTH), .DIVW(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .div     (div),
    .len     (len),
    .arm     (arm),
    .trig    (trig),
    .abort   (abort),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy),
    .overrun (overrun)
  );

  typedef struct {
    logic [15:0] div;
    logic [4:0]  len;
    int          base;
    int          rmode;     // 0: ready held high, 1: 1010 pattern with random stalls
    logic [15:0] exp_hdr;
    int          exp_n;
    int          exp_first;
    int          exp_step;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input logic [15:0] hdr, input int n, input int first, input int step);
    exp_q.delete();
    exp_q.push_back(hdr);
    for (int j = 0; j < n; j++) exp_q.push_back(16'(first + j * step));
  endtask

  // Arms a capture, then drives sig_in = base + k - 1 before edge k (edge 0 takes the arm)
  // and checks every valid word against exp_q, including while stalled.
  task automatic run_capture(input logic [15:0] d, input logic [4:0] l, input int base,
                             input int trig_at, input int rmode, input int rearm_at);
    int k, n_acc, first_k, last_k;
    bit done;
    n_acc = 0; first_k = 0; last_k = 0; done = 1'b0;
    div = d; len = l; trig = 1'b0; m_ready = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    k = 1;
    while (!done && k < MAX_CYC) begin
      sig_in  = 16'(base + k - 1);
      trig    = (k >= trig_at);
      m_ready = (rmode == 0) ? 1'b1 : ((k % 2 == 0) && ($urandom_range(0, 3) != 0));
      arm     = (k == rearm_at);
      if (m_valid) begin
        if (n_acc >= exp_q.size()) begin
          check("extra_word", n_acc, exp_q.size());
          done = 1'b1;
        end else begin
          check($sformatf("word%0d_data", n_acc), m_data, exp_q[n_acc]);
          check($sformatf("word%0d_last", n_acc), m_last, (n_acc == exp_q.size() - 1));
          if (m_ready) begin
            if (n_acc == 0) first_k = k;
            last_k = k;
            n_acc++;
            if (m_last || n_acc == exp_q.size()) done = 1'b1;
          end
        end
      end
      tick();
      k++;
    end
    arm = 1'b0;
    m_ready = 1'b0;
    check("words_received", n_acc, exp_q.size());
    if (rmode == 0) check("throughput_span", last_k - first_k, exp_q.size() - 1);
    check("busy_after_last", busy, 1'b0);
    check("valid_after_last", m_valid, 1'b0);
  endtask

  initial begin
    bit saw_valid;

    vecs[0] = '{div: 16'd0, len: 5'd4,  base: 100,  rmode: 0, exp_hdr: 16'd0, exp_n: 4,  exp_first: 100,  exp_step: 1};
    vecs[1] = '{div: 16'd0, len: 5'd4,  base: 100,  rmode: 1, exp_hdr: 16'd0, exp_n: 4,  exp_first: 100,  exp_step: 1};
    vecs[2] = '{div: 16'd2, len: 5'd5,  base: 200,  rmode: 0, exp_hdr: 16'd2, exp_n: 5,  exp_first: 202,  exp_step: 3};
    vecs[3] = '{div: 16'd0, len: 5'd0,  base: 300,  rmode: 0, exp_hdr: 16'd0, exp_n: 16, exp_first: 300,  exp_step: 1};
    vecs[4] = '{div: 16'd0, len: 5'd1,  base: 50,   rmode: 0, exp_hdr: 16'd0, exp_n: 1,  exp_first: 50,   exp_step: 1};
    vecs[5] = '{div: 16'd1, len: 5'd20, base: 1000, rmode: 1, exp_hdr: 16'd1, exp_n: 16, exp_first: 1001, exp_step: 2};

    rst_n = 1'b0; sig_in = '0; div = '0; len = '0;
    arm = 1'b0; trig = 1'b0; abort = 1'b0; m_ready = 1'b0;
    repeat (3) tick();
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last",  m_last,  1'b0);
    check("rst_m_data",  m_data,  16'd0);
    check("rst_busy",    busy,    1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      build_exp(vecs[v].exp_hdr, vecs[v].exp_n, vecs[v].exp_first, vecs[v].exp_step);
      run_capture(vecs[v].div, vecs[v].len, vecs[v].base, 0, vecs[v].rmode, 0);
      tick();
    end

    // Trigger rises 40 cycles after arm; strobes fall every 10 cycles.
    build_exp(16'd9, 3, 40, 10);
    run_capture(16'd9, 5'd3, 1, 40, 0, 0);
    tick();

    // Arm during CAPTURE: flagged, capture continues untouched.
    build_exp(16'd3, 4, 503, 4);
    run_capture(16'd3, 5'd4, 500, 0, 0, 6);
    check("overrun_set", overrun, 1'b1);
    tick();
    build_exp(16'd0, 2, 600, 1);
    run_capture(16'd0, 5'd2, 600, 0, 0, 0);
    check("overrun_cleared", overrun, 1'b0);
    tick();

    // Abort mid-CAPTURE at sample 2 of 8.
    div = 16'd0; len = 5'd8; trig = 1'b1; arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    tick();
    check("busy_in_capture", busy, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    m_ready = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (m_valid) saw_valid = 1'b1;
      tick();
    end
    check("abort_no_valid", saw_valid, 1'b0);
    m_ready = 1'b0;
    build_exp(16'd0, 2, 700, 1);
    run_capture(16'd0, 5'd2, 700, 0, 0, 0);
    tick();

    // arm and abort together: the arm is dropped.
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    tick();
    check("arm_abort_busy", busy, 1'b0);

    // Reset while the header is held by backpressure.
    div = 16'd5; len = 5'd2; trig = 1'b1; m_ready = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (25) tick();
    check("held_valid", m_valid, 1'b1);
    check("held_header", m_data, 16'd5);
    rst_n = 1'b0;
    tick();
    check("midrst_valid", m_valid, 1'b0);
    check("midrst_last",  m_last,  1'b0);
    check("midrst_busy",  busy,    1'b0);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
